// File: rtl/udp_depkt_pkg.sv
// Shared definitions for the UDP receive path: protocol constants, the
// header word map (2-byte pad / Ethernet / IPv4 / UDP), the parser state
// type and a one's-complement fold helper.
package udp_depkt_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
  localparam logic [7:0]  IPPROTO_UDP    = 8'd17;
  localparam logic [15:0] UDP_HDR_LEN    = 16'd8;

  // Header word positions within a shift16-aligned frame
  localparam logic [3:0] W_DMAC_HI      = 4'd0;   // {pad16, dmac[47:32]}
  localparam logic [3:0] W_DMAC_LO      = 4'd1;   // dmac[31:0]
  localparam logic [3:0] W_SMAC_HI      = 4'd2;   // smac[47:16]
  localparam logic [3:0] W_SMAC_LO      = 4'd3;   // {smac[15:0], ethertype}
  localparam logic [3:0] W_IP_VER_LEN   = 4'd4;   // {ver_ihl, tos, total_len}
  localparam logic [3:0] W_IP_ID        = 4'd5;   // {id, flags_frag}
  localparam logic [3:0] W_IP_TTL_PROTO = 4'd6;   // {ttl, proto, hdr_csum}
  localparam logic [3:0] W_IP_SRC       = 4'd7;   // src_ip
  localparam logic [3:0] W_IP_DST       = 4'd8;   // dst_ip
  localparam logic [3:0] W_UDP_PORTS    = 4'd9;   // {sport, dport}
  localparam logic [3:0] W_UDP_LEN      = 4'd10;  // {udp_len, udp_csum}

  // Payload word counter width: (udp_len - 8) >> 2
  localparam int PAY_CNT_W = 14;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DISCARD = 2'd3
  } state_t;

  // Fold a raw 17-bit sum of two 16-bit values back to 16 bits with
  // end-around carry. When bit 16 is set the low half is at most 16'hFFFE,
  // so the fold never carries out again.
  function automatic logic [15:0] ones_fold(input logic [16:0] x);
    return x[15:0] + {15'd0, x[16]};
  endfunction

endpackage

// File: rtl/udp_depacketizer_ip_csum_acc.sv
// IPv4 header checksum accumulator. Adds two 16-bit halves per enabled
// cycle with end-around carry; o_sum_ok reports whether the folded total
// equals 16'hFFFF (a correct header including its checksum field).
// Only instantiated when UDP_DEPKT_IP_CSUM_EN is defined.
module ip_csum_acc
  import udp_depkt_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_add_en,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic        o_sum_ok
);

  // Raw accumulator: bit 16 is the carry of the last add, folded on the next use
  logic [16:0] r_acc;
  logic [15:0] w_acc_folded;
  logic [15:0] w_sum_a;
  logic [16:0] w_sum_ab;

  assign w_acc_folded = ones_fold(r_acc);
  assign w_sum_a      = ones_fold({1'b0, w_acc_folded} + {1'b0, i_a});
  assign w_sum_ab     = {1'b0, w_sum_a} + {1'b0, i_b};
  assign o_sum_ok     = (w_acc_folded == 16'hFFFF);

  // Accumulate both halves of the current header word; clear on frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_add_en) begin
      r_acc <= w_sum_ab;
    end
  end

endmodule

// File: rtl/udp_depacketizer.sv
// UDP receive depacketizer: parses shift16-aligned Ethernet II / IPv4 / UDP
// frames from the MAC receive FIFO, filters on destination MAC/IP/port and
// forwards whole 32-bit payload words to the Deserializer write port.
// Optional: define UDP_DEPKT_IP_CSUM_EN to verify the IPv4 header checksum.
module udp_depacketizer
  import udp_depkt_pkg::*;
#(
  parameter logic [47:0] local_mac    = 48'h021234566790,
  parameter logic [31:0] local_ip     = {8'd10, 8'd0, 8'd0, 8'd2},
  parameter logic [15:0] local_port   = 16'd32179,
  parameter bit          accept_bcast = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ff_rx_data,
  input  logic        ff_rx_sop,
  input  logic        ff_rx_eop,
  input  logic [1:0]  ff_rx_mod,
  input  logic        ff_rx_dval,
  input  logic [5:0]  rx_err,
  output logic        ff_rx_rdy,
  output logic [31:0] wr_data,
  output logic        wr_en,
  input  logic        wr_afull,
  input  logic        wr_full,
  output logic        pkt_done,
  output logic        pkt_good,
  output logic [15:0] drop_cnt
);

  state_t                 r_state, w_state_next;
  logic [3:0]             r_idx, w_idx_next;
  logic                   r_reject, w_reject_next;
  logic                   r_ovf, w_ovf_next;
  logic [PAY_CNT_W-1:0]   r_count, w_count_next;
  logic [15:0]            r_dmac_hi, w_dmac_hi_next;
  logic                   r_rdy;
  logic [31:0]            r_wr_data, w_wr_data_next;
  logic                   r_wr_en, w_wr_en_next;
  logic                   r_done, w_done_next;
  logic                   r_good, w_good_next;
  logic [15:0]            r_drop_cnt;

  logic [47:0]            w_dmac;
  logic [15:0]            w_udp_body;
  logic [PAY_CNT_W-1:0]   w_pay_words;
  logic                   w_udp_len_ok;
  logic                   w_field_ok;
  logic                   w_unused;

  // Trailing partial bytes are never forwarded, so the eop byte count is not needed
  assign w_unused = ^ff_rx_mod;

  assign w_dmac       = {r_dmac_hi, ff_rx_data};
  assign w_udp_len_ok = (ff_rx_data[31:16] >= UDP_HDR_LEN);
  assign w_udp_body   = ff_rx_data[31:16] - UDP_HDR_LEN;
  assign w_pay_words  = w_udp_body[15:2];

  assign ff_rx_rdy = r_rdy;
  assign wr_data   = r_wr_data;
  assign wr_en     = r_wr_en;
  assign pkt_done  = r_done;
  assign pkt_good  = r_good;
  assign drop_cnt  = r_drop_cnt;

`ifdef UDP_DEPKT_IP_CSUM_EN
  logic w_csum_clear;
  logic w_csum_add;
  logic w_sum_ok;
  logic r_csum_chk, w_csum_chk_next;

  assign w_csum_clear = ff_rx_dval & ff_rx_sop;
  assign w_csum_add   = ff_rx_dval & ~ff_rx_sop & (r_state == HDR) &
                        (r_idx >= W_IP_VER_LEN) & (r_idx <= W_IP_DST);

  ip_csum_acc u_csum (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_csum_clear),
    .i_add_en (w_csum_add),
    .i_a      (ff_rx_data[31:16]),
    .i_b      (ff_rx_data[15:0]),
    .o_sum_ok (w_sum_ok)
  );

  // Checksum verdict is taken the cycle after dst_ip has been accumulated
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_csum_chk <= 1'b0;
    else     r_csum_chk <= w_csum_chk_next;
  end
`endif

  // Per-word header field check selected by the header index
  always_comb begin
    w_field_ok = 1'b1;
    unique case (r_idx)
      W_DMAC_LO:      w_field_ok = (w_dmac == local_mac) ||
                                   (accept_bcast && (w_dmac == 48'hFFFF_FFFF_FFFF));
      W_SMAC_LO:      w_field_ok = (ff_rx_data[15:0] == ETHERTYPE_IPV4);
      W_IP_VER_LEN:   w_field_ok = (ff_rx_data[31:24] == IPV4_VER_IHL);
      W_IP_TTL_PROTO: w_field_ok = (ff_rx_data[23:16] == IPPROTO_UDP);
      W_IP_DST:       w_field_ok = (ff_rx_data == local_ip);
      W_UDP_PORTS:    w_field_ok = (ff_rx_data[15:0] == local_port);
      W_UDP_LEN:      w_field_ok = w_udp_len_ok;
      W_DMAC_HI, W_SMAC_HI, W_IP_ID, W_IP_SRC: w_field_ok = 1'b1;
      default:        w_field_ok = 1'b1;
    endcase
  end

  // Parser next-state, payload forwarding and frame-end status
  always_comb begin
    w_state_next   = r_state;
    w_idx_next     = r_idx;
    w_reject_next  = r_reject;
    w_ovf_next     = r_ovf;
    w_count_next   = r_count;
    w_dmac_hi_next = r_dmac_hi;
    w_wr_en_next   = 1'b0;
    w_wr_data_next = r_wr_data;
    w_done_next    = 1'b0;
    w_good_next    = 1'b0;
`ifdef UDP_DEPKT_IP_CSUM_EN
    w_csum_chk_next = 1'b0;
    if (r_csum_chk && !w_sum_ok) w_reject_next = 1'b1;
`endif
    if (ff_rx_dval) begin
      if (ff_rx_sop) begin
        // A sop outside IDLE aborts the frame in progress as bad
        if (r_state != IDLE) begin
          w_done_next = 1'b1;
          w_good_next = 1'b0;
        end
        w_dmac_hi_next = ff_rx_data[15:0];
        w_reject_next  = 1'b0;
        w_ovf_next     = 1'b0;
        w_count_next   = '0;
        w_idx_next     = W_DMAC_LO;
        if (ff_rx_eop) begin
          w_done_next  = 1'b1;
          w_good_next  = 1'b0;
          w_state_next = IDLE;
        end else begin
          w_state_next = HDR;
        end
      end else begin
        unique case (r_state)
          IDLE: begin
            // words outside a frame are dropped
          end
          HDR: begin
            if (!w_field_ok) w_reject_next = 1'b1;
            w_idx_next = r_idx + 4'd1;
`ifdef UDP_DEPKT_IP_CSUM_EN
            if (r_idx == W_IP_DST) w_csum_chk_next = 1'b1;
`endif
            if (r_idx == W_UDP_LEN) begin
              w_count_next = w_udp_len_ok ? w_pay_words : '0;
              if (!w_reject_next && (w_count_next != '0)) w_state_next = PAYLOAD;
              else                                        w_state_next = DISCARD;
            end
            // eop anywhere in the header is a truncated frame
            if (ff_rx_eop) begin
              w_done_next  = 1'b1;
              w_good_next  = 1'b0;
              w_state_next = IDLE;
            end
          end
          PAYLOAD: begin
            if (wr_full) begin
              w_ovf_next   = 1'b1;
              w_state_next = DISCARD;
            end else begin
              w_wr_en_next   = 1'b1;
              w_wr_data_next = ff_rx_data;
              w_count_next   = r_count - 1'b1;
              if (w_count_next == '0) w_state_next = DISCARD;
            end
            if (ff_rx_eop) begin
              w_done_next  = 1'b1;
              w_good_next  = ~w_reject_next & ~|rx_err & (w_count_next == '0) & ~w_ovf_next;
              w_state_next = IDLE;
            end
          end
          DISCARD: begin
            if (ff_rx_eop) begin
              w_done_next  = 1'b1;
              w_good_next  = ~w_reject_next & ~|rx_err & (r_count == '0) & ~r_ovf;
              w_state_next = IDLE;
            end
          end
          default: w_state_next = IDLE;
        endcase
      end
    end
  end

  // Parser state and frame bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_reject  <= 1'b0;
      r_ovf     <= 1'b0;
      r_count   <= '0;
      r_dmac_hi <= '0;
    end else begin
      r_state   <= w_state_next;
      r_idx     <= w_idx_next;
      r_reject  <= w_reject_next;
      r_ovf     <= w_ovf_next;
      r_count   <= w_count_next;
      r_dmac_hi <= w_dmac_hi_next;
    end
  end

  // Registered outputs: write port, frame status, MAC ready and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy      <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= '0;
      r_done     <= 1'b0;
      r_good     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_rdy     <= ~wr_afull;
      r_wr_en   <= w_wr_en_next;
      r_wr_data <= w_wr_data_next;
      r_done    <= w_done_next;
      r_good    <= w_good_next;
      if (w_done_next && !w_good_next && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_udp_depacketizer.sv
// Testbench for udp_depacketizer: directed frames plus randomized frames,
// each checked against a frame-level reference model (expected payload
// words, good/bad verdict, drop count). Honors UDP_DEPKT_IP_CSUM_EN.
module tb_udp_depacketizer;

  localparam logic [47:0] LMAC  = 48'h021234566790;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [31:0] LIP   = {8'd10, 8'd0, 8'd0, 8'd2};
  localparam logic [15:0] LPORT = 16'd32179;
  localparam int NO_FULL = 100000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ff_rx_data;
  logic        ff_rx_sop, ff_rx_eop, ff_rx_dval;
  logic [1:0]  ff_rx_mod;
  logic [5:0]  rx_err;
  logic        ff_rx_rdy;
  logic [31:0] wr_data;
  logic        wr_en, wr_afull, wr_full;
  logic        pkt_done, pkt_good;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  udp_depacketizer dut (
    .clk(clk), .rst(rst),
    .ff_rx_data(ff_rx_data), .ff_rx_sop(ff_rx_sop), .ff_rx_eop(ff_rx_eop),
    .ff_rx_mod(ff_rx_mod), .ff_rx_dval(ff_rx_dval), .rx_err(rx_err),
    .ff_rx_rdy(ff_rx_rdy), .wr_data(wr_data), .wr_en(wr_en),
    .wr_afull(wr_afull), .wr_full(wr_full),
    .pkt_done(pkt_done), .pkt_good(pkt_good), .drop_cnt(drop_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int frame_no = 0;
  int exp_drop = 0;

  logic [31:0] fw[$];
  logic [31:0] pl[$];
  logic [31:0] got_w[$];
  logic [31:0] exp_w[$];
  bit          got_d[$];
  bit          exp_d[$];

  logic [47:0] h_dmac;
  logic [15:0] h_etype, h_dport, h_ulen;
  logic [7:0]  h_vihl, h_proto;
  logic [31:0] h_dip;
  bit          h_bad_csum;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Collect DUT writes and frame-end verdicts
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en)    got_w.push_back(wr_data);
      if (pkt_done) got_d.push_back(pkt_good);
    end
  end

  // Assemble a frame: header words from fields, then pl[], then pad words
  task automatic build(input logic [47:0] dmac, input logic [15:0] etype,
                       input logic [7:0] vihl, input logic [7:0] proto,
                       input logic [31:0] dip, input logic [15:0] dport,
                       input logic [15:0] ulen, input int pad, input bit bad_csum);
    logic [31:0] hw [5];
    logic [31:0] s;
    logic [15:0] cs;
    hw[0] = {vihl, 8'h00, 16'(ulen + 16'd20)};
    hw[1] = {16'($urandom), 16'h4000};
    hw[2] = {8'd64, proto, 16'h0000};
    hw[3] = 32'hC0A8_0001;
    hw[4] = dip;
    s = 0;
    for (int i = 0; i < 5; i++) s = s + {16'h0, hw[i][31:16]} + {16'h0, hw[i][15:0]};
    while (s > 32'h0000_FFFF) s = (s & 32'h0000_FFFF) + (s >> 16);
    cs = ~s[15:0];
    if (bad_csum) cs = cs + 16'd1;
    hw[2][15:0] = cs;
    fw = {};
    fw.push_back({16'h0000, dmac[47:32]});
    fw.push_back(dmac[31:0]);
    fw.push_back(32'h0A0B_0C0D);
    fw.push_back({16'h0E0F, etype});
    for (int i = 0; i < 5; i++) fw.push_back(hw[i]);
    fw.push_back({16'd5000, dport});
    fw.push_back({ulen, 16'h0000});
    foreach (pl[i]) fw.push_back(pl[i]);
    for (int i = 0; i < pad; i++) fw.push_back($urandom);
    h_dmac = dmac; h_etype = etype; h_vihl = vihl; h_proto = proto;
    h_dip = dip; h_dport = dport; h_ulen = ulen; h_bad_csum = bad_csum;
  endtask

  // Reference model: outcome of sending the first len words of fw
  task automatic expect_frame(input int len, input logic [5:0] err,
                              input int full_idx, input bit has_eop);
    bit rej, ovf, good;
    int cnt, nw;
    rej = !((h_dmac == LMAC) || (h_dmac == BCAST)) || (h_etype != 16'h0800) ||
          (h_vihl != 8'h45) || (h_proto != 8'd17) || (h_dip != LIP) ||
          (h_dport != LPORT) || (h_ulen < 16'd8);
`ifdef UDP_DEPKT_IP_CSUM_EN
    rej = rej || h_bad_csum;
`endif
    cnt = (h_ulen >= 16'd8) ? (int'(h_ulen) - 8) / 4 : 0;
    nw = 0; ovf = 0;
    if (len >= 11 && !rej) begin
      nw = (cnt < len - 11) ? cnt : len - 11;
      if (full_idx >= 11 && full_idx - 11 < nw) begin
        ovf = 1; nw = full_idx - 11;
      end
    end
    for (int i = 0; i < nw; i++) exp_w.push_back(pl[i]);
    good = has_eop && (len >= 12) && !rej && (len - 11 >= cnt) && (err == 0) && !ovf;
    exp_d.push_back(good);
    if (!good && exp_drop < 65535) exp_drop++;
  endtask

  task automatic drive(input int len, input logic [5:0] err, input int full_idx,
                       input bit has_eop, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        @(negedge clk);
        ff_rx_dval = 0; ff_rx_sop = 0; ff_rx_eop = 0; rx_err = 0;
      end
      @(negedge clk);
      ff_rx_dval = 1;
      ff_rx_data = fw[i];
      ff_rx_sop  = (i == 0);
      ff_rx_eop  = has_eop && (i == len - 1);
      ff_rx_mod  = ff_rx_eop ? 2'($urandom) : 2'd0;
      rx_err     = ff_rx_eop ? err : 6'd0;
      wr_full    = (i >= full_idx);
    end
    @(negedge clk);
    ff_rx_dval = 0; ff_rx_sop = 0; ff_rx_eop = 0; rx_err = 0; wr_full = 0;
  endtask

  task automatic settle_and_check(input string name);
    int n;
    repeat (6) @(negedge clk);
    #1;
    chk({name, ".nwr"}, 32'(got_w.size()), 32'(exp_w.size()));
    n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
    for (int i = 0; i < n; i++) chk({name, ".wdata"}, got_w[i], exp_w[i]);
    chk({name, ".ndone"}, 32'(got_d.size()), 32'(exp_d.size()));
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) chk({name, ".good"}, 32'(got_d[i]), 32'(exp_d[i]));
    chk({name, ".drop"}, 32'(drop_cnt), 32'(exp_drop));
    $display("frame %0d %s: writes=%0d dones=%0d drop_cnt=%0d", frame_no, name,
             got_w.size(), got_d.size(), drop_cnt);
    frame_no++;
    got_w = {}; exp_w = {}; got_d = {}; exp_d = {};
  endtask

  task automatic std_frame(input logic [15:0] dport, input logic [15:0] ulen,
                           input int pad, input bit bad_csum);
    build(LMAC, 16'h0800, 8'h45, 8'd17, LIP, dport, ulen, pad, bad_csum);
  endtask

  initial begin
    int plen, len, pad, pw;
    logic [5:0] err;
    logic [47:0] dm;
    logic [15:0] ulen;

    rst = 1; ff_rx_data = 0; ff_rx_sop = 0; ff_rx_eop = 0; ff_rx_mod = 0;
    ff_rx_dval = 0; rx_err = 0; wr_afull = 0; wr_full = 0;
    repeat (3) @(negedge clk);
    chk("rst.rdy", 32'(ff_rx_rdy), 0);
    chk("rst.wr_en", 32'(wr_en), 0);
    chk("rst.wr_data", wr_data, 0);
    chk("rst.done", 32'(pkt_done), 0);
    chk("rst.good", 32'(pkt_good), 0);
    chk("rst.drop", 32'(drop_cnt), 0);
    rst = 0;
    @(negedge clk);
    chk("rdy_after_rst", 32'(ff_rx_rdy), 1);

    // Basic matching frame with two known payload words
    pl = {32'h8000_4000, 32'h1234_5678};
    std_frame(LPORT, 16'd16, 0, 0);
    expect_frame(fw.size(), 0, NO_FULL, 1); drive(fw.size(), 0, NO_FULL, 1, 0);
    settle_and_check("match");

    // Wrong destination port
    std_frame(16'd1234, 16'd16, 0, 0);
    expect_frame(fw.size(), 0, NO_FULL, 1); drive(fw.size(), 0, NO_FULL, 1, 0);
    settle_and_check("bad_port");

    // udp_len=18 with trailing partial word and 24 pad bytes
    pl = {32'h8000_4000, 32'h1234_5678, 32'hABCD_0000};
    std_frame(LPORT, 16'd18, 6, 0);
    expect_frame(fw.size(), 0, NO_FULL, 1); drive(fw.size(), 0, NO_FULL, 1, 0);
    settle_and_check("pad");

    // MAC error on eop
    pl = {32'h8000_4000, 32'h1234_5678};
    std_frame(LPORT, 16'd16, 0, 0);
    expect_frame(fw.size(), 6'h02, NO_FULL, 1); drive(fw.size(), 6'h02, NO_FULL, 1, 0);
    settle_and_check("rx_err");

    // Downstream full before the second payload word
    std_frame(LPORT, 16'd16, 0, 0);
    expect_frame(fw.size(), 0, 12, 1); drive(fw.size(), 0, 12, 1, 0);
    settle_and_check("wr_full");

    // sop after w6 aborts, then a complete frame parses
    std_frame(LPORT, 16'd16, 0, 0);
    expect_frame(7, 0, NO_FULL, 0); drive(7, 0, NO_FULL, 0, 0);
    pl = {32'hCAFE_0001, 32'hCAFE_0002};
    std_frame(LPORT, 16'd16, 0, 0);
    expect_frame(fw.size(), 0, NO_FULL, 1); drive(fw.size(), 0, NO_FULL, 1, 0);
    settle_and_check("abort");

    // Corrupted IPv4 header checksum (rejected only with checksum checking built)
    std_frame(LPORT, 16'd16, 0, 1);
    expect_frame(fw.size(), 0, NO_FULL, 1); drive(fw.size(), 0, NO_FULL, 1, 0);
    settle_and_check("csum");

    // Backpressure: ready follows ~wr_afull one clock later
    @(negedge clk); wr_afull = 1;
    @(negedge clk); chk("afull.rdy_low", 32'(ff_rx_rdy), 0);
    wr_afull = 0;
    @(negedge clk); chk("afull.rdy_high", 32'(ff_rx_rdy), 1);
    $display("frame %0d afull: ready toggle checked", frame_no);

    // Randomized frames with occasional field errors, truncation and MAC errors
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(15))
        0:       dm = LMAC ^ (48'h1 << $urandom_range(47));
        1:       dm = BCAST;
        default: dm = LMAC;
      endcase
      ulen = ($urandom_range(15) == 0) ? 16'($urandom_range(7)) : 16'(8 + $urandom_range(40));
      pw = (ulen >= 16'd8) ? (int'(ulen) - 8 + 3) / 4 : 0;
      pl = {};
      for (int i = 0; i < pw; i++) pl.push_back($urandom);
      pad = $urandom_range(1, 6);
      build(dm,
            ($urandom_range(15) == 0) ? 16'h86DD : 16'h0800,
            ($urandom_range(15) == 0) ? 8'h46 : 8'h45,
            ($urandom_range(15) == 0) ? 8'd6 : 8'd17,
            ($urandom_range(15) == 0) ? (LIP ^ (32'h1 << $urandom_range(31))) : LIP,
            ($urandom_range(15) == 0) ? (LPORT ^ 16'h0001) : LPORT,
            ulen, pad, 0);
      plen = fw.size();
      len  = ($urandom_range(7) == 0) ? $urandom_range(1, plen) : plen;
      err  = ($urandom_range(7) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      expect_frame(len, err, NO_FULL, 1);
      drive(len, err, NO_FULL, 1, $urandom_range(1) == 1);
      settle_and_check("rand");
    end

    // Reset in the middle of a frame: no pulse, counter cleared, then recovery
    pl = {32'h1111_2222, 32'h3333_4444};
    std_frame(LPORT, 16'd16, 0, 0);
    drive(9, 0, NO_FULL, 0, 0);
    rst = 1;
    @(negedge clk); @(negedge clk);
    chk("midrst.done", 32'(pkt_done), 0);
    chk("midrst.drop", 32'(drop_cnt), 0);
    rst = 0;
    exp_drop = 0;
    @(negedge clk);
    expect_frame(fw.size(), 0, NO_FULL, 1); drive(fw.size(), 0, NO_FULL, 1, 0);
    settle_and_check("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/udp_depacketizer.md
Name: udp_depacketizer

Overview:
- Receive-side counterpart of the Packetizer. Consumes the Ethernet MAC receive stream (ff_rx_*) and parses Ethernet II, IPv4 and UDP headers.
- Filters frames by destination MAC, IP and port, and forwards whole 32-bit UDP payload words to the Deserializer write port.
- Reports per-frame good/bad status and keeps a saturating drop counter.

Parameters:
- local_mac, 48'h021234566790, accepted destination MAC.
- local_ip, {8'd10,8'd0,8'd0,8'd2}, accepted destination IPv4 address.
- local_port, 16'd32179, accepted UDP destination port.
- accept_bcast, 1, also accept destination MAC 48'hFFFFFFFFFFFF.

Ports:
- clk  in  1  system clock, also drives ff_rx_clk domain.
- rst  in  1  asynchronous, active-high reset.
- ff_rx_data  in  32  MAC receive data, big-endian byte order ([31:24] is the first byte).
- ff_rx_sop  in  1  start of frame.
- ff_rx_eop  in  1  end of frame.
- ff_rx_mod  in  2  number of invalid bytes in the eop word.
- ff_rx_dval  in  1  data valid.
- rx_err  in  6  MAC error flags; valid on the eop word.
- ff_rx_rdy  out  1  ready to MAC.
- wr_data  out  32  payload word to the Deserializer.
- wr_en  out  1  payload write strobe.
- wr_afull  in  1  downstream almost full; downstream guarantees at least 3 free words while it is asserted.
- wr_full  in  1  downstream full.
- pkt_done  out  1  one-cycle frame-end pulse.
- pkt_good  out  1  valid when pkt_done is high; 1 if the frame passed all checks.
- drop_cnt  out  16  saturating count of frames ended with pkt_good=0.

Behaviour:
- Reset: ff_rx_rdy=0, wr_en=0, wr_data=0, pkt_done=0, pkt_good=0, drop_cnt=0, state=IDLE. ff_rx_rdy rises on the first clock after reset release. Reset mid-frame discards the frame with no pkt_done.
- ff_rx_rdy = ~wr_afull, registered. MAC ready latency is 2. Every dval word is accepted regardless of ff_rx_rdy.
- MAC runs with RX shift16, so each frame carries 2 leading pad bytes and the payload is word-aligned.
- Header words:
  - w0 {pad16, dmac[47:32]}
  - w1 dmac[31:0]
  - w2 smac[47:16]
  - w3 {smac[15:0], ethertype}
  - w4 {ver_ihl, tos, total_len}
  - w5 {id, flags_frag}
  - w6 {ttl, proto, hdr_csum}
  - w7 src_ip
  - w8 dst_ip
  - w9 {sport, dport}
  - w10 {udp_len, udp_csum}
  - w11 onward: payload.
- States:
  - IDLE: wait for dval&sop, then HDR with hdr_idx=1 after checking w0.
  - HDR: a 4-bit index selects the checked field.
    - Any mismatch sets a sticky reject flag. The frame still runs to eop, so all frames are consumed.
    - Checks: dmac==local_mac, or (accept_bcast and broadcast); ethertype==16'h0800; ver_ihl==8'h45; proto==8'd17; dst_ip==local_ip; dport==local_port; udp_len>=8.
    - At w10: payload word count = (udp_len-8)>>2, 14 bits. Trailing 1-3 bytes are ignored.
    - Next state is PAYLOAD if not rejected and count>0, else DISCARD.
    - Rejected frames produce pkt_good=0. A zero-length payload with no reject produces pkt_good=1.
  - PAYLOAD: each dval word is driven on wr_data with wr_en high on the next cycle (1-cycle latency), and the count is decremented. At count 0 the state goes to DISCARD, which absorbs Ethernet minimum-frame padding.
  - DISCARD: ignore words until eop.
- Frame end: the eop word is processed, then on the following cycle pkt_done=1 and the state returns to IDLE.
  - pkt_good = ~reject & ~|rx_err & count_exhausted & ~overflow.
  - Payload words already written are not retracted; the Deserializer uses pkt_good to discard them.
- eop arriving in HDR or in PAYLOAD with count>0: truncated frame, pkt_good=0.
- sop arriving while not IDLE: abort the current frame with pkt_done=1 and pkt_good=0 in the same cycle. The new word is treated as w0.
- A payload word arriving while wr_full=1: the word is not written, overflow is set, and the state moves to DISCARD.
- sop&eop in the same word: frame is truncated and bad.
- drop_cnt increments on every pkt_done with pkt_good=0 and holds at 16'hFFFF.

Optional Feature:
- Macro: UDP_DEPKT_IP_CSUM_EN.
- When defined: IPv4 header checksum is verified. The 16-bit halves of w4..w8 are accumulated with end-around carry in a 17-bit accumulator. A final sum other than 16'hFFFF sets reject at w8 processing, one cycle after w8 arrives; this is still before payload.
- When not defined: hdr_csum is ignored and no accumulator logic is built.

Decomposition:
- Package udp_depkt_pkg:
  - ETHERTYPE_IPV4=16'h0800, IPV4_VER_IHL=8'h45, IPPROTO_UDP=8'd17, UDP_HDR_LEN=16'd8.
  - Header word indexes W_DMAC_HI..W_UDP_LEN (0..10).
  - State enum IDLE/HDR/PAYLOAD/DISCARD.
- Sub-module ip_csum_acc (clear, add16 x2 per cycle, sum_ok). Instantiated only under UDP_DEPKT_IP_CSUM_EN.

Test Plan:
- Matching frame, udp_len=16 (2 payload words 32'h8000_4000 and 32'h1234_5678), no error -> two wr_en pulses carrying those words in order, then pkt_done=1, pkt_good=1, drop_cnt=0.
- Same frame with dport=16'd1234 -> no wr_en, pkt_done=1, pkt_good=0, drop_cnt=1.
- Matching frame, udp_len=18, with 24 pad bytes after payload -> exactly 2 payload words written, padding discarded, pkt_good=1.
- Matching frame, rx_err=6'h02 on eop -> payload written, pkt_good=0.
- wr_full=1 asserted before the 2nd payload word -> only 1 word written, pkt_good=0.
- new sop after w6 of a frame -> abort pulse with pkt_good=0, then the second frame parses to pkt_good=1.
- wr_afull=1 -> ff_rx_rdy=0 one cycle later.
- Build with UDP_DEPKT_IP_CSUM_EN; corrupt hdr_csum by 1 -> pkt_good=0, no wr_en.
